// File: rtl/stage4_accum_pkg.sv
// Shared types, default widths and arithmetic helpers for the stage-4 accumulator.
// Optional saturation is selected in the top with macro STAGE4_ACC_SAT_EN.
package stage4_accum_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 26;
    localparam int unsigned ACC_WIDTH_DEF      = 32;
    localparam int unsigned WARMUP_SAMPLES_DEF = 27;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_e;

    // Sign-extend the low 'width' bits of value to 64 bits (width in 1..64).
    function automatic logic [63:0] sign_extend(input logic [63:0] value, input int unsigned width);
        logic [63:0] upper;
        upper = ~64'd0 << width;
        return value[6'(width - 1)] ? (value | upper) : (value & ~upper);
    endfunction

    // A widened signed sum overflowed the narrow result when its top two bits differ.
    function automatic logic add_overflow(input logic sum_top, input logic sum_next);
        return sum_top ^ sum_next;
    endfunction

endpackage

// File: rtl/stage4_accum_part_if.sv
// Sample-in / accumulator-out bus of the stage-4 integrator.
interface stage4_accum_part_if
    import stage4_accum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
);
    logic                  CLR;
    logic                  DIN_VALID;
    logic [DATA_WIDTH-1:0] DATAIN;
    logic                  DOUT_VALID;
    logic [ACC_WIDTH-1:0]  DATAOUT;
    logic                  RUNNING;
    logic                  OVF;

    modport master (
        output CLR, DIN_VALID, DATAIN,
        input  DOUT_VALID, DATAOUT, RUNNING, OVF
    );

    modport slave (
        input  CLR, DIN_VALID, DATAIN,
        output DOUT_VALID, DATAOUT, RUNNING, OVF
    );
endinterface

// File: rtl/stage4_warmup_ctr.sv
// Saturating warm-up sample counter; done_c flags that the count reaches COUNT_MAX this edge.
module stage4_warmup_ctr #(
    parameter int unsigned COUNT_MAX = 27
) (
    input  logic SYS_CLK,
    input  logic RESET_N,
    input  logic clr,
    input  logic inc,
    output logic done_c
);
    localparam int unsigned CW = (COUNT_MAX == 0) ? 1 : $clog2(COUNT_MAX + 1);
    localparam logic [CW-1:0] MAX_V = CW'(COUNT_MAX);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_V)) begin
            count_d = count_q + CW'(1);
        end
    end

    assign done_c = (count_d == MAX_V);

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stage4_accum_part.sv
// Stage-4 recursive accumulator y[n] = y[n-1] + x[n], gated by an upstream warm-up count.
// Define STAGE4_ACC_SAT_EN to clamp on overflow instead of two's-complement wrap.
module stage4_accum_part
    import stage4_accum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH      = ACC_WIDTH_DEF,
    parameter int unsigned WARMUP_SAMPLES = WARMUP_SAMPLES_DEF
) (
    input  logic SYS_CLK,
    input  logic RESET_N,
    stage4_accum_part_if.slave bus
);
    localparam int unsigned SW          = ACC_WIDTH + 1;
    localparam state_e      RESET_STATE = (WARMUP_SAMPLES == 0) ? RUN : WARMUP;
    localparam logic [ACC_WIDTH-1:0] ACC_POS_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_NEG_MAX = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_e               state_q;
    state_e               state_d;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 dout_valid_q;
    logic                 dout_valid_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 running_q;
    logic                 running_d;

    logic [SW-1:0]        sum_c;
    logic                 ovf_c;
    logic                 ctr_inc_c;
    logic                 ctr_done_c;

    // Full-precision sum of the accumulator and the incoming sample.
    assign sum_c = SW'(sign_extend(64'(bus.DATAIN), DATA_WIDTH))
                 + SW'(sign_extend(64'(acc_q), ACC_WIDTH));
    assign ovf_c = add_overflow(sum_c[SW-1], sum_c[SW-2]);

    // Clear wins over a coincident sample, so that sample is never counted.
    assign ctr_inc_c = bus.DIN_VALID && !bus.CLR && (state_q == WARMUP);

    stage4_warmup_ctr #(
        .COUNT_MAX (WARMUP_SAMPLES)
    ) u_warmup_ctr (
        .SYS_CLK (SYS_CLK),
        .RESET_N (RESET_N),
        .clr     (bus.CLR),
        .inc     (ctr_inc_c),
        .done_c  (ctr_done_c)
    );

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.CLR) begin
            state_d = RESET_STATE;
        end else begin
            case (state_q)
                WARMUP:  if (ctr_done_c) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = RESET_STATE;
            endcase
        end
    end

    always_comb begin
        acc_d        = acc_q;
        dout_valid_d = 1'b0;
        ovf_d        = ovf_q;
        running_d    = (state_d == RUN);
        if (bus.CLR) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if ((state_q == RUN) && bus.DIN_VALID) begin
            dout_valid_d = 1'b1;
            ovf_d        = ovf_q | ovf_c;
`ifdef STAGE4_ACC_SAT_EN
            if (ovf_c) begin
                acc_d = sum_c[SW-1] ? ACC_NEG_MAX : ACC_POS_MAX;
            end else begin
                acc_d = sum_c[ACC_WIDTH-1:0];
            end
`else
            acc_d = sum_c[ACC_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_q        <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            running_q    <= (RESET_STATE == RUN);
        end else begin
            acc_q        <= acc_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
            running_q    <= running_d;
        end
    end

    assign bus.DATAOUT    = acc_q;
    assign bus.DOUT_VALID = dout_valid_q;
    assign bus.OVF        = ovf_q;
    assign bus.RUNNING    = running_q;

`ifndef STAGE4_ACC_SAT_EN
    logic unused_sat_consts;
    assign unused_sat_consts = ^{ACC_POS_MAX, ACC_NEG_MAX};
`endif

endmodule

// File: tb/tb_stage4_accum_part.sv
// Directed scoreboard bench for stage4_accum_part (default build and a zero-warm-up instance).
module tb_stage4_accum_part;

    localparam longint AMAX = 64'sd2147483647;
    localparam longint AMIN = -64'sd2147483648;
    localparam longint MOD  = 64'sd4294967296;

    logic SYS_CLK = 1'b0;
    logic RESET_N;
    always #5 SYS_CLK = ~SYS_CLK;

    stage4_accum_part_if #(.DATA_WIDTH(26), .ACC_WIDTH(32)) bus0 ();
    stage4_accum_part_if #(.DATA_WIDTH(26), .ACC_WIDTH(32)) bus1 ();

    stage4_accum_part #(.DATA_WIDTH(26), .ACC_WIDTH(32), .WARMUP_SAMPLES(27)) dut0 (
        .SYS_CLK (SYS_CLK),
        .RESET_N (RESET_N),
        .bus     (bus0)
    );

    stage4_accum_part #(.DATA_WIDTH(26), .ACC_WIDTH(32), .WARMUP_SAMPLES(0)) dut1 (
        .SYS_CLK (SYS_CLK),
        .RESET_N (RESET_N),
        .bus     (bus1)
    );

    int     n_cmp = 0;
    int     n_err = 0;
    longint macc;
    int     mcnt;
    bit     mrun;
    bit     movf;
    bit     exp_v;
    bit     mon_en;
    longint expq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    task automatic model_reset();
        macc = 0;
        mcnt = 0;
        movf = 1'b0;
        mrun = 1'b0;
        exp_v = 1'b0;
        expq.delete();
    endtask

    // Drive one cycle of stimulus on dut0 and advance the reference model.
    task automatic drive(input longint d, input bit v, input bit c);
        @(negedge SYS_CLK);
        bus0.CLR       = c;
        bus0.DIN_VALID = v;
        bus0.DATAIN    = 26'(d);
        exp_v = 1'b0;
        if (c) begin
            macc = 0;
            mcnt = 0;
            movf = 1'b0;
            mrun = 1'b0;
        end else if (v) begin
            if (!mrun) begin
                mcnt++;
                if (mcnt == 27) mrun = 1'b1;
            end else begin
                longint s;
                s = macc + d;
                if (s > AMAX || s < AMIN) begin
                    movf = 1'b1;
`ifdef STAGE4_ACC_SAT_EN
                    s = (s > AMAX) ? AMAX : AMIN;
`else
                    s = (s > AMAX) ? (s - MOD) : (s + MOD);
`endif
                end
                macc = s;
                exp_v = 1'b1;
                expq.push_back(s);
            end
        end
    endtask

    // Per-cycle monitor: valid strobe, scoreboard data, held value and flags.
    always @(posedge SYS_CLK) begin
        #1;
        if (mon_en) begin
            chk("dout_valid", 64'(bus0.DOUT_VALID), 64'(exp_v));
            if (bus0.DOUT_VALID === 1'b1) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL scoreboard_underflow observed=output expected=none");
                end else begin
                    chk("dataout_sb", sx(bus0.DATAOUT), expq.pop_front());
                end
            end
            chk("dataout_hold", sx(bus0.DATAOUT), macc);
            chk("running", 64'(bus0.RUNNING), 64'(mrun));
            chk("ovf", 64'(bus0.OVF), 64'(movf));
        end
        exp_v = 1'b0;
    end

    initial begin
        RESET_N        = 1'b0;
        bus0.CLR       = 1'b0;
        bus0.DIN_VALID = 1'b0;
        bus0.DATAIN    = '0;
        bus1.CLR       = 1'b0;
        bus1.DIN_VALID = 1'b0;
        bus1.DATAIN    = '0;
        mon_en         = 1'b0;
        model_reset();

        #12;
        chk("rst_dataout", sx(bus0.DATAOUT), 0);
        chk("rst_dout_valid", 64'(bus0.DOUT_VALID), 0);
        chk("rst_ovf", 64'(bus0.OVF), 0);
        chk("rst_running", 64'(bus0.RUNNING), 0);
        chk("rst_running_w0", 64'(bus1.RUNNING), 1);
        @(negedge SYS_CLK);
        RESET_N = 1'b1;
        mon_en  = 1'b1;

        // Warm-up: 27 discarded samples, then the 28th is the first output.
        for (int i = 0; i < 26; i++) drive(100, 1'b1, 1'b0);
        @(posedge SYS_CLK);
        #2;
        chk("t1_running_before", 64'(bus0.RUNNING), 0);
        drive(100, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t1_running_after", 64'(bus0.RUNNING), 1);
        chk("t1_no_output", 64'(bus0.DOUT_VALID), 0);
        drive(100, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t1_first_valid", 64'(bus0.DOUT_VALID), 1);
        chk("t1_first_data", sx(bus0.DATAOUT), 100);

        // Back-to-back samples then gap cycles.
        drive(10, 1'b1, 1'b0);
        drive(20, 1'b1, 1'b0);
        drive(-5, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0);
        drive(7, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t2_last_data", sx(bus0.DATAOUT), 132);
        drive(0, 1'b0, 1'b0);
        chk("t2_gap_valid", 64'(bus0.DOUT_VALID), 0);
        chk("t2_gap_hold", sx(bus0.DATAOUT), 132);

        // Clear coincident with a sample: sample dropped, warm-up restarts.
        drive(1102, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t4_preclr", sx(bus0.DATAOUT), 1234);
        drive(50, 1'b1, 1'b1);
        drive(0, 1'b0, 1'b0);
        chk("t4_clr_data", sx(bus0.DATAOUT), 0);
        chk("t4_clr_ovf", 64'(bus0.OVF), 0);
        chk("t4_clr_running", 64'(bus0.RUNNING), 0);
        for (int i = 0; i < 26; i++) drive(7, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t4_running_26", 64'(bus0.RUNNING), 0);
        drive(7, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t4_running_27", 64'(bus0.RUNNING), 1);
        drive(5, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t4_first_data", sx(bus0.DATAOUT), 5);

        // Preload to 2^31-10, then push past the positive limit.
        for (int i = 0; i < 64; i++) drive(33554431, 1'b1, 1'b0);
        drive(49, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t3_preload", sx(bus0.DATAOUT), 2147483638);
        drive(20, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
`ifdef STAGE4_ACC_SAT_EN
        chk("t3_ovf_data", sx(bus0.DATAOUT), 2147483647);
`else
        chk("t3_ovf_data", sx(bus0.DATAOUT), -64'sd2147483638);
`endif
        chk("t3_ovf_flag", 64'(bus0.OVF), 1);
        drive(-100, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t3_ovf_sticky", 64'(bus0.OVF), 1);

        // Asynchronous reset pulse between clock edges.
        drive(3, 1'b1, 1'b0);
        mon_en = 1'b0;
        @(negedge SYS_CLK);
        bus0.DIN_VALID = 1'b0;
        #1 RESET_N = 1'b0;
        #1;
        chk("t5_dataout", sx(bus0.DATAOUT), 0);
        chk("t5_dout_valid", 64'(bus0.DOUT_VALID), 0);
        chk("t5_ovf", 64'(bus0.OVF), 0);
        chk("t5_running", 64'(bus0.RUNNING), 0);
        model_reset();
        #1 RESET_N = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) drive(9, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0);
        chk("t5_rewarm", 64'(bus0.RUNNING), 0);

        // Zero warm-up instance accumulates from the first sample.
        @(negedge SYS_CLK);
        bus1.DIN_VALID = 1'b1;
        bus1.DATAIN    = 26'(-3);
        @(negedge SYS_CLK);
        bus1.DIN_VALID = 1'b0;
        chk("t6_valid", 64'(bus1.DOUT_VALID), 1);
        chk("t6_data", sx(bus1.DATAOUT), -64'sd3);
        chk("t6_running", 64'(bus1.RUNNING), 1);
        @(negedge SYS_CLK);
        chk("t6_valid_drop", 64'(bus1.DOUT_VALID), 0);

        chk("sb_drained", 64'(expq.size()), 0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
